// File: rtl/shift_rotate_pkg.sv
// Shared definitions for the multi-cycle shift/rotate engine:
// opcode encodings and FSM state encoding.
package shift_rotate_pkg;

   localparam logic [2:0] OP_SHL = 3'b000;
   localparam logic [2:0] OP_SHR = 3'b001;
   localparam logic [2:0] OP_SAR = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;
   localparam logic [2:0] OP_RCL = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Opcodes 110 and 111 are reserved.
   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_RCL;
   endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step.
// Ports: w/carry   - current working value and carry
//        opcode    - operation select
//        w_next/carry_next - value and carry after one 1-bit step
module shift_step
   import shift_rotate_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] w,
   input  logic             carry,
   input  logic [2:0]       opcode,
   output logic [WIDTH-1:0] w_next,
   output logic             carry_next
);

   // Carry always receives the bit leaving the operand.
   always_comb begin
      w_next     = w;
      carry_next = carry;
      case (opcode)
         OP_SHL: begin w_next = {w[WIDTH-2:0], 1'b0};       carry_next = w[WIDTH-1]; end
         OP_SHR: begin w_next = {1'b0, w[WIDTH-1:1]};       carry_next = w[0];       end
         OP_SAR: begin w_next = {w[WIDTH-1], w[WIDTH-1:1]}; carry_next = w[0];       end
         OP_ROL: begin w_next = {w[WIDTH-2:0], w[WIDTH-1]}; carry_next = w[WIDTH-1]; end
         OP_ROR: begin w_next = {w[0], w[WIDTH-1:1]};       carry_next = w[0];       end
         OP_RCL: begin w_next = {w[WIDTH-2:0], carry};      carry_next = w[WIDTH-1]; end
         default: ;
      endcase
   end

endmodule

// File: rtl/shift_rotate_seq.sv
// Multi-cycle shift/rotate engine: one bit position per clock.
// Ports: clk, rst (async active-high)
//        in_valid/in_ready, in_a, in_opcode, in_amt, in_cin - request handshake
//        out_valid/out_ready, out_result, out_carry, out_err - result handshake
module shift_rotate_seq
   import shift_rotate_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [2:0]         in_opcode,
   input  logic [SHAMT_W-1:0] in_amt,
   input  logic               in_cin,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_result,
   output logic               out_carry,
   output logic               out_err
);

   state_t             state, state_next;
   logic [WIDTH-1:0]   w, w_step;
   logic               carry, carry_step;
   logic [SHAMT_W-1:0] count;
   logic [2:0]         op;
   logic               accept;
   logic               last_step;

   logic               in_ready_d, out_valid_d, out_carry_d, out_err_d;
   logic [WIDTH-1:0]   out_result_d;

   assign accept    = in_valid && in_ready;
   assign last_step = (count == SHAMT_W'(1));

   shift_step #(.WIDTH(WIDTH)) u_step (
      .w          (w),
      .carry      (carry),
      .opcode     (op),
      .w_next     (w_step),
      .carry_next (carry_step)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!op_legal(in_opcode) || in_amt == '0) state_next = DONE;
               else                                      state_next = SHIFT;
            end
         end
         SHIFT: if (last_step) state_next = DONE;
         DONE:  if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: next values for the registered outputs.
   always_comb begin
      in_ready_d   = (state_next == IDLE);
      out_valid_d  = (state_next == DONE);
      out_result_d = out_result;
      out_carry_d  = out_carry;
      out_err_d    = out_err;
      if (state == IDLE && accept && state_next == DONE) begin
         // Zero-length or illegal request: operand passes straight through.
         out_result_d = in_a;
         out_carry_d  = (in_opcode == OP_RCL) ? in_cin : 1'b0;
         out_err_d    = !op_legal(in_opcode);
      end else if (state == SHIFT && last_step) begin
         out_result_d = w_step;
         out_carry_d  = carry_step;
         out_err_d    = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_carry  <= 1'b0;
         out_err    <= 1'b0;
      end else begin
         in_ready   <= in_ready_d;
         out_valid  <= out_valid_d;
         out_result <= out_result_d;
         out_carry  <= out_carry_d;
         out_err    <= out_err_d;
      end
   end

   // Working datapath: loaded on accept, stepped once per SHIFT cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w     <= '0;
         carry <= 1'b0;
         count <= '0;
         op    <= OP_SHL;
      end else if (state == IDLE && accept) begin
         w     <= in_a;
         carry <= (in_opcode == OP_RCL) ? in_cin : 1'b0;
         count <= in_amt;
         op    <= in_opcode;
      end else if (state == SHIFT) begin
         w     <= w_step;
         carry <= carry_step;
         count <= count - SHAMT_W'(1);
      end
   end

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed self-checking bench for shift_rotate_seq (WIDTH=8).
module tb_shift_rotate_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [2:0] in_opcode;
   logic [2:0] in_amt;
   logic       in_cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_result;
   logic       out_carry;
   logic       out_err;

   int tests = 0;
   int fails = 0;

   localparam int MAX_LAT = 40;

   shift_rotate_seq #(.WIDTH(8), .SHAMT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_opcode  (in_opcode),
      .in_amt     (in_amt),
      .in_cin     (in_cin),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_carry  (out_carry),
      .out_err    (out_err)
   );

   always #5 clk = ~clk;

   // Present one request, then count cycles until out_valid (bounded).
   task automatic run_op(input logic [7:0] a, input logic [2:0] op,
                         input logic [2:0] amt, input logic cin, output int lat);
      in_a = a; in_opcode = op; in_amt = amt; in_cin = cin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < MAX_LAT) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_opcode = '0; in_amt = '0; in_cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({in_ready, out_valid, out_result, out_carry, out_err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset: rdy=%b vld=%b res=%h c=%b e=%b, want rdy=1 vld=0 res=00 c=0 e=0",
                  in_ready, out_valid, out_result, out_carry, out_err);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Run one legal op and check latency, result, carry, err.
   task automatic test_shift(input string name, input logic [7:0] a, input logic [2:0] op,
                             input logic [2:0] amt, input logic cin,
                             input logic [7:0] exp_res, input logic exp_c);
      int lat;
      run_op(a, op, amt, cin, lat);
      tests++;
      if (lat !== int'(amt) + 1) begin
         fails++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, int'(amt) + 1);
      end
      tests++;
      if ({out_result, out_carry, out_err} !== {exp_res, exp_c, 1'b0}) begin
         fails++;
         $display("FAIL %s result: got res=%b c=%b e=%b want res=%b c=%b e=0",
                  name, out_result, out_carry, out_err, exp_res, exp_c);
      end
      release_out();
   endtask

   task automatic test_ops();
      test_shift("shl3", 8'b10110101, 3'b000, 3'd3, 1'b0, 8'b10101000, 1'b1);
      test_shift("shr2", 8'b10110101, 3'b001, 3'd2, 1'b0, 8'b00101101, 1'b0);
      test_shift("sar3", 8'b10110101, 3'b010, 3'd3, 1'b0, 8'b11110110, 1'b1);
      test_shift("rol4", 8'b10110101, 3'b011, 3'd4, 1'b0, 8'b01011011, 1'b1);
      test_shift("ror1", 8'b10110101, 3'b100, 3'd1, 1'b0, 8'b11011010, 1'b1);
      test_shift("rcl1", 8'b10110101, 3'b101, 3'd1, 1'b0, 8'b01101010, 1'b1);
      test_shift("rcl3", 8'b10110101, 3'b101, 3'd3, 1'b1, 8'b10101110, 1'b1);
      test_shift("rcl0", 8'b10110101, 3'b101, 3'd0, 1'b1, 8'b10110101, 1'b1);
      test_shift("shl0", 8'b10110101, 3'b000, 3'd0, 1'b1, 8'b10110101, 1'b0);
      test_shift("shr7", 8'b10000000, 3'b001, 3'd7, 1'b0, 8'b00000001, 1'b0);
   endtask

   // Illegal opcode: 1-cycle latency, passthrough, err; outputs hold while stalled.
   task automatic test_illegal_hold();
      int lat;
      run_op(8'h5A, 3'b110, 3'd5, 1'b1, lat);
      tests++;
      if (lat !== 1) begin
         fails++;
         $display("FAIL illegal latency: got %0d want 1", lat);
      end
      // A competing request during DONE must not be taken.
      in_a = 8'hFF; in_opcode = 3'b000; in_amt = 3'd1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if ({out_valid, in_ready, out_result, out_carry, out_err} !== {1'b1, 1'b0, 8'h5A, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL illegal hold[%0d]: vld=%b rdy=%b res=%h c=%b e=%b want vld=1 rdy=0 res=5a c=0 e=1",
                     i, out_valid, in_ready, out_result, out_carry, out_err);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      release_out();
      tests++;
      if ({out_valid, in_ready} !== 2'b01) begin
         fails++;
         $display("FAIL illegal release: vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      end
      run_op(8'h3C, 3'b111, 3'd0, 1'b0, lat);
      tests++;
      if ({lat == 1, out_result, out_carry, out_err} !== {1'b1, 8'h3C, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL illegal111: lat=%0d res=%h c=%b e=%b want lat=1 res=3c c=0 e=1",
                  lat, out_result, out_carry, out_err);
      end
      release_out();
   endtask

   // Reset mid-shift aborts; engine is usable immediately after.
   task automatic test_reset_mid();
      int lat;
      in_a = 8'hFF; in_opcode = 3'b000; in_amt = 3'd7; in_cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if ({out_valid, in_ready} !== 2'b01) begin
         fails++;
         $display("FAIL reset_mid: vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid no output: vld=%b want 0", out_valid);
      end
      run_op(8'h81, 3'b000, 3'd1, 1'b0, lat);
      tests++;
      if ({lat == 2, out_result, out_carry, out_err} !== {1'b1, 8'h02, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL after_reset shl1: lat=%0d res=%h c=%b e=%b want lat=2 res=02 c=1 e=0",
                  lat, out_result, out_carry, out_err);
      end
      release_out();
   endtask

   initial begin
      test_reset();
      test_ops();
      test_illegal_hold();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
